// File: rtl/nonrestoring_divider_seq.sv
// Iterative unsigned non-restoring divider: one add/subtract step per clock, then one correction cycle.
// Optional macro DIV_BY_ZERO_DETECT_EN short-cuts a zero divisor and raises o_div_by_zero.
module nonrestoring_divider_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StIter, StCorr} state_e;

  state_e            r_state, w_state_next;
  logic [WIDTH:0]    r_p;
  logic [WIDTH-1:0]  r_a, r_d, r_q;
  logic [CntW-1:0]   r_cnt;
  logic              r_done, r_div_by_zero, r_dbz_pend;
  logic [WIDTH-1:0]  r_quotient, r_remainder;

  logic              w_skip;
  logic [WIDTH:0]    w_t, w_p_step, w_p_corr;

`ifdef DIV_BY_ZERO_DETECT_EN
  assign w_skip = (i_divisor == '0);
`else
  assign w_skip = 1'b0;
`endif

  // The sign bit of P is dropped before the shift; arithmetic is modulo 2^(WIDTH+1).
  assign w_t      = {r_p[WIDTH-1:0], r_a[WIDTH-1]};
  assign w_p_step = r_p[WIDTH] ? (w_t + {1'b0, r_d}) : (w_t - {1'b0, r_d});
  assign w_p_corr = r_p + ({1'b0, r_d} & {(WIDTH + 1){r_p[WIDTH]}});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: if (i_start) w_state_next = w_skip ? StCorr : StIter;
      StIter: if (r_cnt == CntW'(1)) w_state_next = StCorr;
      StCorr: w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_p           <= '0;
      r_a           <= '0;
      r_d           <= '0;
      r_q           <= '0;
      r_cnt         <= '0;
      r_done        <= 1'b0;
      r_div_by_zero <= 1'b0;
      r_dbz_pend    <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_a           <= i_dividend;
            r_d           <= i_divisor;
            r_cnt         <= CntW'(WIDTH);
            r_dbz_pend    <= w_skip;
            r_div_by_zero <= 1'b0;
            // A skipped zero divisor preloads the final answer so CORR passes it straight through.
            if (w_skip) begin
              r_p <= {1'b0, i_dividend};
              r_q <= '1;
            end else begin
              r_p <= '0;
              r_q <= '0;
            end
          end
        end
        StIter: begin
          r_p   <= w_p_step;
          r_q   <= {r_q[WIDTH-2:0], ~w_p_step[WIDTH]};
          r_a   <= r_a << 1;
          r_cnt <= r_cnt - CntW'(1);
        end
        StCorr: begin
          r_p           <= w_p_corr;
          r_quotient    <= r_q;
          r_remainder   <= w_p_corr[WIDTH-1:0];
          r_done        <= 1'b1;
          r_div_by_zero <= r_dbz_pend;
        end
        default: ;
      endcase
    end
  end

  assign o_busy        = (r_state != StIdle);
  assign o_done        = r_done;
  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_nonrestoring_divider_seq.sv
// Directed bench for nonrestoring_divider_seq at WIDTH=8 and WIDTH=16.
// Honours DIV_BY_ZERO_DETECT_EN for the zero-divisor expectations.
module tb_nonrestoring_divider_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        s8, busy8, done8, dbz8;
  logic [7:0]  a8, b8, q8, r8;
  logic        s16, busy16, done16, dbz16;
  logic [15:0] a16, b16, q16, r16;

  int checks = 0;
  int failures = 0;

`ifdef DIV_BY_ZERO_DETECT_EN
  localparam int Lat0_8 = 1;
  localparam int Lat0_16 = 1;
  localparam logic Dbz0 = 1'b1;
`else
  localparam int Lat0_8 = 9;
  localparam int Lat0_16 = 17;
  localparam logic Dbz0 = 1'b0;
`endif

  nonrestoring_divider_seq #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(s8), .i_dividend(a8), .i_divisor(b8),
    .o_busy(busy8), .o_done(done8), .o_quotient(q8), .o_remainder(r8), .o_div_by_zero(dbz8)
  );

  nonrestoring_divider_seq #(.WIDTH(16)) u_dut16 (
    .i_clk(clk), .i_rst(rst), .i_start(s16), .i_dividend(a16), .i_divisor(b16),
    .o_busy(busy16), .o_done(done16), .o_quotient(q16), .o_remainder(r16),
    .o_div_by_zero(dbz16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done8(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (done8 !== 1'b1 && n < 40);
  endtask

  task automatic wait_done16(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (done16 !== 1'b1 && n < 40);
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                      input int elat);
    int n;
    @(negedge clk); a8 = a; b8 = b; s8 = 1'b1;
    @(posedge clk); #1; s8 = 1'b0;
    chk({tag, "_busy"}, busy8, 1);
    wait_done8(n);
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_q"}, q8, eq);
    chk({tag, "_r"}, r8, er);
    chk({tag, "_dbz"}, dbz8, edbz);
    chk({tag, "_busy_done"}, busy8, 0);
    @(posedge clk); #1;
    chk({tag, "_done_fall"}, done8, 0);
  endtask

  task automatic run16(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                       input int elat);
    int n;
    @(negedge clk); a16 = a; b16 = b; s16 = 1'b1;
    @(posedge clk); #1; s16 = 1'b0;
    wait_done16(n);
    chk({tag, "_lat"}, n, elat);
    chk({tag, "_q"}, q16, eq);
    chk({tag, "_r"}, r16, er);
    chk({tag, "_dbz"}, dbz16, edbz);
  endtask

  initial begin
    int n;
    int pulses;
    logic [15:0] ra, rb;
    s8 = 1'b0; a8 = '0; b8 = '0;
    s16 = 1'b0; a16 = '0; b16 = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_q", q8, 0);
    chk("rst_r", r8, 0);
    chk("rst_dbz", dbz8, 0);
    chk("rst16_q", q16, 0);
    @(negedge clk); rst = 1'b0;

    // Directed WIDTH=8 vectors
    run8("d100_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 9);
    run8("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 9);
    run8("d5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9);
    run8("d200_13", 8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 9);
    run8("d0_5", 8'd0, 8'd5, 8'd0, 8'd0, 1'b0, 9);
    run8("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 9);
    run8("d254_255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 9);
    run8("dz5a", 8'h5A, 8'h00, 8'hFF, 8'h5A, Dbz0, Lat0_8);
    run8("d17_4", 8'd17, 8'd4, 8'd4, 8'd1, 1'b0, 9);
    chk("dbz_clear", dbz8, 0);

    // start pulsed while busy is ignored, then start held in the done cycle chains
    @(negedge clk); a8 = 8'd100; b8 = 8'd7; s8 = 1'b1;
    @(posedge clk); #1; s8 = 1'b0;
    n = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      if (i == 3) begin a8 = 8'd200; b8 = 8'd3; s8 = 1'b1; end
      if (i == 4) s8 = 1'b0;
      if (done8 === 1'b1) begin n = i; break; end
    end
    chk("ign_lat", n, 9);
    chk("ign_q", q8, 14);
    chk("ign_r", r8, 2);
    a8 = 8'd255; b8 = 8'd1; s8 = 1'b1;
    @(posedge clk); #1; s8 = 1'b0;
    chk("b2b_done_fall", done8, 0);
    chk("b2b_busy", busy8, 1);
    wait_done8(n);
    chk("b2b_lat", n, 9);
    chk("b2b_q", q8, 255);
    chk("b2b_r", r8, 0);

    // Reset in the middle of an operation
    @(negedge clk); a8 = 8'd100; b8 = 8'd7; s8 = 1'b1;
    @(posedge clk); #1; s8 = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b1;
    #1;
    chk("mrst_busy", busy8, 0);
    chk("mrst_done", done8, 0);
    chk("mrst_q", q8, 0);
    chk("mrst_r", r8, 0);
    chk("mrst_dbz", dbz8, 0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) pulses++;
    end
    chk("mrst_no_done", pulses, 0);
    run8("post_rst_5_9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0, 9);

    // WIDTH=16 directed vectors
    run16("w16_50000_123", 16'd50000, 16'd123, 16'd406, 16'd62, 1'b0, 17);
    run16("w16_65535_255", 16'd65535, 16'd255, 16'd257, 16'd0, 1'b0, 17);
    run16("w16_1000_65535", 16'd1000, 16'd65535, 16'd0, 16'd1000, 1'b0, 17);
    run16("w16_zero", 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, Dbz0, Lat0_16);

    // WIDTH=16 randomised sweep
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 2 == 1) rb = rb & 16'h00FF;
      if (rb == 16'd0) rb = 16'd1;
      run16("rnd", ra, rb, ra / rb, ra % rb, 1'b0, 17);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
